// File: rtl/acc_stack_ctrl.sv
// Accumulator controller with a push/pop stack and carry/zero flags.
// Commands go IDLE -> EXEC -> RESP; results stay on rsp_* until taken.
module acc_stack_ctrl #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [3:0]               cmd_op,
    input  logic [WIDTH-1:0]         cmd_data,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WIDTH-1:0]         rsp_data,
    output logic                     rsp_zero,
    output logic                     rsp_carry,
    output logic                     rsp_err,
    output logic [$clog2(DEPTH):0]   sp
);

    localparam int AW  = $clog2(DEPTH);
    localparam int SPW = AW + 1;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LOAD = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_XOR  = 4'h6;
    localparam logic [3:0] OP_NOT  = 4'h7;
    localparam logic [3:0] OP_INC  = 4'h8;
    localparam logic [3:0] OP_DEC  = 4'h9;
    localparam logic [3:0] OP_ROR  = 4'hA;
    localparam logic [3:0] OP_SHR  = 4'hB;
    localparam logic [3:0] OP_ROL  = 4'hC;
    localparam logic [3:0] OP_SHL  = 4'hD;
    localparam logic [3:0] OP_PUSH = 4'hE;
    localparam logic [3:0] OP_POP  = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_e;

    state_e           state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;
    logic             err_q, err_d;
    logic [SPW-1:0]   sp_q, sp_d;

    logic [WIDTH-1:0] stack_q [DEPTH];
    logic             push_en;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    rd_idx;
    logic [WIDTH:0]   sum;
    logic             full;
    logic             empty;

    assign wr_idx = sp_q[AW-1:0];
    assign rd_idx = AW'(sp_q - 1'b1);
    assign full   = (sp_q == SPW'(DEPTH));
    assign empty  = (sp_q == '0);

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        data_d    = data_q;
        acc_d     = acc_q;
        carry_d   = carry_q;
        zero_d    = zero_q;
        err_d     = err_q;
        sp_d      = sp_q;
        push_en   = 1'b0;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        sum       = '0;
        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    data_d  = cmd_data;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                err_d   = 1'b0;
                state_d = RESP;
                case (op_q)
                    OP_NOP: ;
                    OP_LOAD: begin
                        acc_d   = data_q;
                        carry_d = 1'b0;
                    end
                    OP_ADD: begin
                        sum     = {1'b0, acc_q} + {1'b0, data_q};
                        acc_d   = sum[WIDTH-1:0];
                        carry_d = sum[WIDTH];
                    end
                    OP_SUB: begin
                        sum     = {1'b0, acc_q} - {1'b0, data_q};
                        acc_d   = sum[WIDTH-1:0];
                        carry_d = sum[WIDTH];
                    end
                    OP_AND: begin
                        acc_d   = acc_q & data_q;
                        carry_d = 1'b0;
                    end
                    OP_OR: begin
                        acc_d   = acc_q | data_q;
                        carry_d = 1'b0;
                    end
                    OP_XOR: begin
                        acc_d   = acc_q ^ data_q;
                        carry_d = 1'b0;
                    end
                    OP_NOT: begin
                        acc_d   = ~acc_q;
                        carry_d = 1'b0;
                    end
                    OP_INC: begin
                        sum     = {1'b0, acc_q} + (WIDTH+1)'(1);
                        acc_d   = sum[WIDTH-1:0];
                        carry_d = sum[WIDTH];
                    end
                    OP_DEC: begin
                        // borrow appears in the extra top bit
                        sum     = {1'b0, acc_q} - (WIDTH+1)'(1);
                        acc_d   = sum[WIDTH-1:0];
                        carry_d = sum[WIDTH];
                    end
                    OP_ROR: begin
                        acc_d   = {acc_q[0], acc_q[WIDTH-1:1]};
                        carry_d = acc_q[0];
                    end
                    OP_SHR: begin
                        acc_d   = {1'b0, acc_q[WIDTH-1:1]};
                        carry_d = acc_q[0];
                    end
                    OP_ROL: begin
                        acc_d   = {acc_q[WIDTH-2:0], acc_q[WIDTH-1]};
                        carry_d = acc_q[WIDTH-1];
                    end
                    OP_SHL: begin
                        acc_d   = {acc_q[WIDTH-2:0], 1'b0};
                        carry_d = acc_q[WIDTH-1];
                    end
                    OP_PUSH: begin
                        if (full) begin
                            err_d = 1'b1;
                        end else begin
                            push_en = 1'b1;
                            sp_d    = sp_q + 1'b1;
                        end
                    end
                    OP_POP: begin
                        if (empty) begin
                            err_d = 1'b1;
                        end else begin
                            acc_d = stack_q[rd_idx];
                            sp_d  = sp_q - 1'b1;
                        end
                    end
                    default: ;
                endcase
                zero_d = (acc_d == '0);
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= '0;
            data_q  <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b1;
            err_q   <= 1'b0;
            sp_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            data_q  <= data_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
            err_q   <= err_d;
            sp_q    <= sp_d;
        end
    end

    // stack storage is not reset; sp alone defines what is valid
    always_ff @(posedge clk) begin
        if (push_en && !reset) begin
            stack_q[wr_idx] <= acc_q;
        end
    end

    assign rsp_data  = acc_q;
    assign rsp_zero  = zero_q;
    assign rsp_carry = carry_q;
    assign rsp_err   = err_q;
    assign sp        = sp_q;

endmodule

// File: tb/tb_acc_stack_ctrl.sv
// Directed and random checks for acc_stack_ctrl against a
// behavioural accumulator/stack model feeding a result queue.
module tb_acc_stack_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_op;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_zero;
    logic       rsp_carry;
    logic       rsp_err;
    logic [3:0] sp;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [7:0] d;
        logic       z;
        logic       c;
        logic       e;
        logic [3:0] sp;
    } exp_t;

    exp_t sb [$];

    logic [7:0] m_acc;
    logic       m_c;
    int         m_sp;
    logic [7:0] m_stk [8];

    acc_stack_ctrl #(.WIDTH(8), .DEPTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_zero  (rsp_zero),
        .rsp_carry (rsp_carry),
        .rsp_err   (rsp_err),
        .sp        (sp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_acc = 8'h00;
        m_c   = 1'b0;
        m_sp  = 0;
    endtask

    task automatic model_step(input logic [3:0] op, input logic [7:0] d);
        exp_t e;
        logic err;
        err = 1'b0;
        case (op)
            4'h0: ;
            4'h1: begin m_acc = d; m_c = 1'b0; end
            4'h2: begin m_c = (int'(m_acc) + int'(d)) > 255; m_acc = m_acc + d; end
            4'h3: begin m_c = (m_acc < d); m_acc = m_acc - d; end
            4'h4: begin m_acc = m_acc & d; m_c = 1'b0; end
            4'h5: begin m_acc = m_acc | d; m_c = 1'b0; end
            4'h6: begin m_acc = m_acc ^ d; m_c = 1'b0; end
            4'h7: begin m_acc = ~m_acc; m_c = 1'b0; end
            4'h8: begin m_c = (m_acc == 8'hFF); m_acc = m_acc + 8'd1; end
            4'h9: begin m_c = (m_acc == 8'h00); m_acc = m_acc - 8'd1; end
            4'hA: begin m_c = m_acc[0]; m_acc = {m_acc[0], m_acc[7:1]}; end
            4'hB: begin m_c = m_acc[0]; m_acc = m_acc >> 1; end
            4'hC: begin m_c = m_acc[7]; m_acc = {m_acc[6:0], m_acc[7]}; end
            4'hD: begin m_c = m_acc[7]; m_acc = m_acc << 1; end
            4'hE: begin
                if (m_sp == 8) err = 1'b1;
                else begin m_stk[m_sp] = m_acc; m_sp++; end
            end
            default: begin
                if (m_sp == 0) err = 1'b1;
                else begin m_sp--; m_acc = m_stk[m_sp]; end
            end
        endcase
        e.d  = m_acc;
        e.z  = (m_acc == 8'h00);
        e.c  = m_c;
        e.e  = err;
        e.sp = 4'(m_sp);
        sb.push_back(e);
    endtask

    task automatic run(input logic [3:0] op, input logic [7:0] d,
                       input int hold);
        exp_t e;
        model_step(op, d);
        @(negedge clk);
        chk("idle_cmd_ready", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        rsp_ready = (hold == 0);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_op    = 4'($urandom);
        cmd_data  = 8'($urandom);
        chk("exec_rsp_valid", rsp_valid, 0);
        chk("exec_cmd_ready", cmd_ready, 0);
        @(posedge clk); #1;
        chk("rsp_valid", rsp_valid, 1);
        chk("sb_nonempty", sb.size() > 0, 1);
        e = sb.pop_front();
        chk("rsp_data", rsp_data, e.d);
        chk("rsp_zero", rsp_zero, e.z);
        chk("rsp_carry", rsp_carry, e.c);
        chk("rsp_err", rsp_err, e.e);
        chk("sp", sp, e.sp);
        for (int i = 0; i < hold; i++) begin
            cmd_valid = 1'b1;
            cmd_op    = 4'h1;
            cmd_data  = 8'h5A;
            @(posedge clk); #1;
            chk("hold_rsp_valid", rsp_valid, 1);
            chk("hold_cmd_ready", cmd_ready, 0);
            chk("hold_rsp_data", rsp_data, e.d);
            chk("hold_rsp_flags", {rsp_zero, rsp_carry, rsp_err},
                {e.z, e.c, e.e});
            chk("hold_sp", sp, e.sp);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("back_idle_ready", cmd_ready, 1);
        chk("back_idle_valid", rsp_valid, 0);
    endtask

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 4'h0;
        cmd_data  = 8'h00;
        rsp_ready = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_zero", rsp_zero, 1);
        chk("rst_rsp_carry", rsp_carry, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_sp", sp, 0);
        @(negedge clk);
        reset = 1'b0;

        // add with carry out
        run(4'h1, 8'hF0, 0);
        run(4'h2, 8'h20, 0);
        // subtract to zero, then borrow
        run(4'h1, 8'h01, 0);
        run(4'h3, 8'h01, 0);
        run(4'h9, 8'h00, 0);
        // shifts and rotates
        run(4'h1, 8'h81, 0);
        run(4'hA, 8'h00, 0);
        run(4'hB, 8'h00, 0);
        run(4'hD, 8'h00, 0);
        run(4'hC, 8'h00, 0);
        // logic ops, INC wrap, NOP
        run(4'h4, 8'h0F, 0);
        run(4'h5, 8'hA0, 0);
        run(4'h6, 8'hFF, 0);
        run(4'h7, 8'h00, 0);
        run(4'h1, 8'hFF, 0);
        run(4'h8, 8'h00, 0);
        run(4'h0, 8'h77, 0);

        // fill the stack, overflow, drain, underflow
        for (int v = 1; v <= 8; v++) begin
            run(4'h1, 8'(v), 0);
            run(4'hE, 8'h00, 0);
        end
        run(4'hE, 8'h00, 0);
        for (int v = 0; v < 8; v++) run(4'hF, 8'h00, 0);
        run(4'hF, 8'h00, 0);

        // consumer back-pressure
        run(4'h1, 8'h3C, 5);
        run(4'h0, 8'h00, 0);

        for (int i = 0; i < 30; i++)
            run(4'($urandom_range(0, 15)), 8'($urandom), i % 7 == 3 ? 2 : 0);

        // reset while a PUSH is in EXEC
        model_reset();
        run(4'h1, 8'h42, 0);
        for (int i = 0; i < 3; i++) run(4'hE, 8'h00, 0);
        chk("pre_rst_sp", sp, 3);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 4'hE;
        cmd_data  = 8'h00;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        reset     = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        chk("mid_rst_cmd_ready", cmd_ready, 1);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        chk("mid_rst_sp", sp, 0);
        chk("mid_rst_acc", rsp_data, 0);
        chk("mid_rst_flags", {rsp_zero, rsp_carry, rsp_err}, 3'b100);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("mid_rst_no_rsp", rsp_valid, 0);
        end
        run(4'hF, 8'h00, 0);
        run(4'h8, 8'h00, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
